// File: rtl/sig_mon_pkg.sv
// Shared types and default constants for the signal period monitor.
package sig_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } mon_state_e;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TIMEOUT  = 1000;
    localparam int DEF_EDGE_W   = 8;
    localparam int DEF_FILT_LEN = 3;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes sig_in into the clock domain and emits a registered one-cycle edge pulse.
// Optional glitch filter enabled by defining SIG_MON_GLITCH_FILTER_EN.
module sig_sync_edge
    import sig_mon_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic lvl;

`ifdef SIG_MON_GLITCH_FILTER_EN
    localparam int STAB_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);

    logic [STAB_W-1:0] stab_q;

    // The new level is accepted combinationally on its FILT_LEN-th consecutive sample,
    // which keeps the extra latency at FILT_LEN-1 cycles.
    assign lvl = (sync2 != prev && stab_q == STAB_LAST) ? sync2 : prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stab_q <= '0;
        end else begin
            stab_q <= (sync2 != lvl) ? stab_q + 1'b1 : '0;
        end
    end
`else
    assign lvl = sync2;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= sig_in;
            sync2      <= sync1;
            prev       <= lvl;
            edge_pulse <= (lvl != prev);
        end
    end

endmodule

// File: rtl/sig_period_monitor.sv
// Measures half-period and toggle count of an asynchronous signal, flagging loss of toggling.
// Optional glitch filter in the front end is enabled by defining SIG_MON_GLITCH_FILTER_EN.
module sig_period_monitor
    import sig_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int EDGE_W   = DEF_EDGE_W,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sig_in,
    input  logic              clear,
    output logic [CNT_W-1:0]  half_period,
    output logic              period_valid,
    output logic [EDGE_W-1:0] edge_count,
    output logic              active,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mon_state_e        state_q;
    mon_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  hp_d;
    logic              pv_d;
    logic [EDGE_W-1:0] ec_d;
    logic [EDGE_W-1:0] ec_inc;
    logic              edge_pulse;

    sig_sync_edge #(
        .FILT_LEN(FILT_LEN)
    ) u_sync_edge (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .edge_pulse(edge_pulse)
    );

    assign ec_inc = (&edge_count) ? edge_count : edge_count + 1'b1;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = half_period;
        pv_d    = 1'b0;
        ec_d    = edge_count;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (edge_pulse) begin
                    state_d = FIRST;
                    cnt_d   = CNT_ONE;
                    ec_d    = ec_inc;
                end
            end
            FIRST, TRACK: begin
                if (edge_pulse) begin
                    cnt_d = CNT_ONE;
                    ec_d  = ec_inc;
                    // An edge landing on the saturated count restarts tracking; TIMEOUT is never reported.
                    if (cnt_q == TO_VAL) begin
                        state_d = FIRST;
                    end else begin
                        state_d = TRACK;
                        hp_d    = cnt_q;
                        pv_d    = 1'b1;
                    end
                end else if (cnt_q == TO_VAL) begin
                    state_d = LOST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOST: begin
                if (edge_pulse) begin
                    state_d = FIRST;
                    cnt_d   = CNT_ONE;
                    ec_d    = ec_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            hp_d    = '0;
            pv_d    = 1'b0;
            ec_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            edge_count   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            half_period  <= hp_d;
            period_valid <= pv_d;
            edge_count   <= ec_d;
        end
    end

    assign active  = (state_q == TRACK);
    assign timeout = (state_q == LOST);

endmodule

// File: doc/sig_period_monitor.md
Name: sig_period_monitor

Overview:
- Downstream consumer of the toggling signal generator.
- Brings the asynchronous `sig` into the `clock` domain and detects its edges.
- Measures the half-period (clock cycles between consecutive edges) and counts toggles.
- Flags loss of toggling after a programmable timeout; used to check the generator's enable-gated output in synthesizable form.

Parameters:
- CNT_W, 16: width of the interval counter and of `half_period`.
- TIMEOUT, 1000: clock cycles without an edge before loss is declared. Must satisfy 2 <= TIMEOUT < 2^CNT_W.
- EDGE_W, 8: width of `edge_count`.
- FILT_LEN, 3: stability length for the optional glitch filter. Must be >= 2.

Ports:
- clock, input, 1: sole clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- sig_in, input, 1: monitored signal; asynchronous to `clock`.
- clear, input, 1: synchronous soft clear.
- half_period, output, CNT_W: last measured edge-to-edge interval in clocks.
- period_valid, output, 1: one-cycle pulse when `half_period` updates.
- edge_count, output, EDGE_W: detected edges since reset/clear; saturating.
- active, output, 1: high while toggling is being tracked.
- timeout, output, 1: high while toggling is lost.

Behaviour:
- Reset values:
  - `half_period`=0, `period_valid`=0, `edge_count`=0, `active`=0, `timeout`=0.
  - state=IDLE, interval counter=0, synchronizer flops=0.
- Synchronizer and edge detect:
  - Two-flop synchronizer, then a registered previous value; an edge is sync_out != prev.
  - Rising and falling edges are treated identically.
  - An edge is detected on the 3rd rising `clock` after the first clock edge that samples the new `sig_in` level.
  - `period_valid` and `half_period` update on that same clock edge.
- Interval counter:
  - On each detected edge, loads 1.
  - Otherwise increments while state is FIRST or TRACK, stopping at TIMEOUT.
  - Never wraps.
- State machine:
  - IDLE: counter held 0. Edge -> FIRST; `edge_count`++.
  - FIRST: one edge seen, no interval yet, `active`=0.
    - Edge -> TRACK: `half_period`<=counter, `period_valid` pulse, `edge_count`++.
    - Counter reaches TIMEOUT -> LOST.
  - TRACK: `active`=1.
    - Edge -> stay: `half_period`<=counter, `period_valid` pulse, `edge_count`++.
    - Counter reaches TIMEOUT -> LOST.
  - LOST: `timeout`=1, `active`=0, counter held.
    - Edge -> FIRST: `timeout` clears, `edge_count`++, no `period_valid`; the interval spanning the loss is discarded.
- `edge_count` saturates at 2^EDGE_W-1.
- Timeout boundary:
  - An edge detected on the same cycle the counter would reach TIMEOUT counts as an edge.
  - A measurement equal to TIMEOUT-1 is reported; TIMEOUT is never reported.
- `clear`:
  - Returns state to IDLE; zeroes counter, `half_period`, `edge_count`, `timeout`, `active`.
  - Synchronizer and prev flops are NOT cleared, so no spurious edge follows.
  - `clear` coincident with an edge: clear wins and the edge is dropped.
- Async `reset` mid-operation:
  - All state returns to reset values immediately, independent of `clock`.
  - First edge after release is handled from IDLE.

Optional Feature:
- Macro: SIG_MON_GLITCH_FILTER_EN.
- Defined:
  - Filtered level changes only after the synchronized value holds the new level for FILT_LEN consecutive clocks.
  - Adds FILT_LEN-1 cycles of detection latency.
  - Pulses shorter than FILT_LEN clocks produce no edges.
  - Clean-signal intervals are unchanged.
- Undefined: the synchronized value drives edge detection directly; no extra latency.

Decomposition:
- Shared package / include `sig_mon_pkg`:
  - state encodings IDLE=2'd0, FIRST=2'd1, TRACK=2'd2, LOST=2'd3.
  - default TIMEOUT and FILT_LEN constants.
- Sub-module `sig_sync_edge`:
  - Contains the two-flop synchronizer, optional filter and prev flop.
  - Outputs `edge_pulse`.
  - Takes `clock` and `reset` only (no `clear`).

Test Plan:
- `sig_in` toggles every 10 clocks, 6 edges -> `period_valid` pulses 5 times, each with `half_period`=10; `edge_count`=6; `active`=1 from the 2nd edge.
- Toggling stops after edge 4 with TIMEOUT=50 -> `timeout`=1 and `active`=0 exactly 50 clocks after the last edge; the next edge clears `timeout` without a `period_valid` pulse.
- Async `reset` asserted mid-TRACK between clock edges -> all outputs 0 immediately; after release, the first edge enters FIRST and no `period_valid` pulse occurs.
- `clear` asserted on the same cycle an edge is detected -> state IDLE, `edge_count`=0, no `period_valid` pulse; the next toggle 10 clocks later gives `edge_count`=1.
- Macro defined, FILT_LEN=3, a 1-clock high glitch on an idle `sig_in` -> `edge_count` remains 0.
- Macro undefined, same 1-clock glitch -> `edge_count`=2.
- EDGE_W=4, 20 edges at 8-clock spacing -> `edge_count` saturates at 15; `half_period`=8 on every pulse.
